// File: rtl/mgmt_gpio_ctrl.sv
// Management GPIO pad controller: Wishbone regs, blink sequencer,
// pad input sync with sticky edge flag. Optional macro: MGMT_GPIO_IRQ_EN.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, sync active-high reset
//   wb_cyc_i/stb_i/we_i       Wishbone cycle, strobe, write enable
//   wb_sel_i[3:0]             byte lane select
//   wb_adr_i[3:0]             byte address, [3:2] = register index
//   wb_dat_i/wb_dat_o[31:0]   write / read data (read valid with ack)
//   wb_ack_o                  single-cycle acknowledge
//   gpio_in_pad               asynchronous pad input
//   gpio_out_pad              pad output value
//   gpio_outenb_pad           output enable, active low
//   gpio_inenb_pad            input enable, active low
//   gpio_mode0/1_pad          pad drive mode
//   gpio_irq                  edge interrupt (0 without MGMT_GPIO_IRQ_EN)
module mgmt_gpio_ctrl #(
  parameter int PW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        gpio_in_pad,
  output logic        gpio_out_pad,
  output logic        gpio_outenb_pad,
  output logic        gpio_inenb_pad,
  output logic        gpio_mode0_pad,
  output logic        gpio_mode1_pad,
  output logic        gpio_irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [PW-1:0] ONE = PW'(1);

  logic                   r_ack;
  logic [31:0]            r_dat;
  logic [5:0]             r_ctrl;
  logic [PW-1:0]          r_period;
  logic [PW-1:0]          r_cnt;
  logic [7:0]             r_count;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_flag;
  logic                   r_out;
  logic                   r_outenb;
  logic                   r_inenb;
  logic                   r_mode0;
  logic                   r_mode1;

  logic        w_req;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_per;
  logic        w_wr_cnt;
  logic        w_wr_stat;
  logic [31:0] w_wmask;
  logic [PW-1:0] w_pmask;
  logic [PW-1:0] w_eff_m1;
  logic        w_hit;
  logic        w_busy;
  logic        w_blink_q;
  logic        w_sync;
  logic        w_edge;
  logic        w_irq_en;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_req     = wb_cyc_i & wb_stb_i;
  // Writes commit on the edge that closes the ack cycle.
  assign w_wr      = w_req & wb_we_i & r_ack;
  assign w_wr_ctrl = w_wr & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0];
  assign w_wr_per  = w_wr & (wb_adr_i[3:2] == 2'd1);
  assign w_wr_cnt  = w_wr & (wb_adr_i[3:2] == 2'd2) & wb_sel_i[0];
  assign w_wr_stat = w_wr & (wb_adr_i[3:2] == 2'd3) & wb_sel_i[0];

  assign w_wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                    {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_pmask = w_wmask[PW-1:0];

  // Period 0 behaves as 1; >= lets a shortened period end the phase.
  assign w_eff_m1  = (r_period == '0) ? '0 : r_period - ONE;
  assign w_hit     = (r_cnt >= w_eff_m1);
  assign w_busy    = (r_state != S_IDLE);
  assign w_blink_q = (r_state == S_HIGH);

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = w_sync ^ r_prev;

  assign w_unused = &{1'b0, wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    w_rdata = '0;
    unique case (wb_adr_i[3:2])
      2'd0: w_rdata = {26'd0, r_ctrl};
      2'd1: w_rdata = 32'(r_period);
      2'd2: w_rdata = {24'd0, r_count};
      2'd3: w_rdata = {28'd0, w_irq_en, w_busy, r_flag, w_sync};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & ~r_ack;
      r_dat <= (w_req & ~r_ack & ~wb_we_i) ? w_rdata : '0;
    end
  end

  // Pad control pins only follow CTRL when it is written, so the
  // reset drive (input enabled) holds until software configures it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ctrl   <= '0;
      r_period <= '0;
      r_outenb <= 1'b1;
      r_inenb  <= 1'b0;
      r_mode0  <= 1'b0;
      r_mode1  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl   <= wb_dat_i[5:0];
        r_outenb <= ~wb_dat_i[1];
        r_inenb  <= ~wb_dat_i[2];
        r_mode0  <= wb_dat_i[3];
        r_mode1  <= wb_dat_i[4];
      end
      if (w_wr_per) begin
        r_period <= (r_period & ~w_pmask)
                  | (wb_dat_i[PW-1:0] & w_pmask);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_count <= '0;
    end else if (w_wr_cnt) begin
      r_state <= S_HIGH;
      r_cnt   <= '0;
      r_count <= wb_dat_i[7:0];
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
        end
        S_HIGH: begin
          if (w_hit) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        S_LOW: begin
          if (w_hit) begin
            r_cnt <= '0;
            if (r_count == 8'd1) begin
              r_state <= S_IDLE;
              r_count <= '0;
            end else if (r_count == 8'd0) begin
              r_state <= S_HIGH;
            end else begin
              r_state <= S_HIGH;
              r_count <= r_count - 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_out <= 1'b0;
    end else begin
      r_out <= (r_ctrl[5] & w_busy) ? w_blink_q : r_ctrl[0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in_pad};
      r_prev <= w_sync;
      // A new edge beats a simultaneous W1C.
      if (w_edge) begin
        r_flag <= 1'b1;
      end else if (w_wr_stat & wb_dat_i[1]) begin
        r_flag <= 1'b0;
      end
    end
  end

`ifdef MGMT_GPIO_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_stat) begin
        r_irq_en <= wb_dat_i[3];
      end
      r_irq <= r_flag & r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign gpio_irq = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign gpio_irq = 1'b0;
`endif

  assign wb_ack_o        = r_ack;
  assign wb_dat_o        = r_dat;
  assign gpio_out_pad    = r_out;
  assign gpio_outenb_pad = r_outenb;
  assign gpio_inenb_pad  = r_inenb;
  assign gpio_mode0_pad  = r_mode0;
  assign gpio_mode1_pad  = r_mode1;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Testbench for mgmt_gpio_ctrl: directed steps with randomized values,
// checked against a timing model of registers, blink and input paths.
module tb_mgmt_gpio_ctrl;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        wbwe = 1'b0;
  logic [3:0]  wbsel = 4'h0;
  logic [3:0]  wbadr = 4'h0;
  logic [31:0] wbdat = '0;
  logic [31:0] dato;
  logic        ack;
  logic        gin = 1'b0;
  logic        gout;
  logic        goeb;
  logic        gieb;
  logic        gm0;
  logic        gm1;
  logic        girq;

  mgmt_gpio_ctrl #(.PW(24), .SYNC_STAGES(SS)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wb_cyc_i        (cyc),
    .wb_stb_i        (stb),
    .wb_we_i         (wbwe),
    .wb_sel_i        (wbsel),
    .wb_adr_i        (wbadr),
    .wb_dat_i        (wbdat),
    .wb_dat_o        (dato),
    .wb_ack_o        (ack),
    .gpio_in_pad     (gin),
    .gpio_out_pad    (gout),
    .gpio_outenb_pad (goeb),
    .gpio_inenb_pad  (gieb),
    .gpio_mode0_pad  (gm0),
    .gpio_mode1_pad  (gm1),
    .gpio_irq        (girq)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  int   tickn = 0;
  logic prev_ack = 1'b0;
  logic chk_pad = 1'b0;

  // blink model: current run and the run it replaced
  int   m_nc = 0, m_P = 1, m_N = 0;
  bit   m_act = 0;
  int   p_nc = 0, p_P = 1, p_N = 0;
  bit   p_act = 0;
  logic m_ov = 1'b0;
  logic m_in = 1'b0;
  logic m_flag = 1'b0;
  logic m_irq_en = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pad at tick t reflects the sequencer state one tick earlier.
  function automatic logic model_pad(int t);
    int k, p, n;
    bit a;
    k = t - 1 - m_nc; p = m_P; n = m_N; a = m_act;
    if (k < 0) begin
      k = t - 1 - p_nc; p = p_P; n = p_N; a = p_act;
    end
    if (!a || k < 0) return m_ov;
    if (n != 0 && k / (2 * p) >= n) return m_ov;
    return (k % (2 * p)) < p;
  endfunction

  function automatic logic [31:0] exp_count(int r0);
    int j;
    j = (r0 - m_nc) / (2 * m_P);
    if (m_N == 0 || j >= m_N) return 0;
    return 32'(m_N - j);
  endfunction

  function automatic logic exp_busy(int r0);
    if (!m_act) return 1'b0;
    return (m_N == 0) || ((r0 - m_nc) / (2 * m_P) < m_N);
  endfunction

  function automatic logic [31:0] exp_stat(logic busy);
    return {28'd0, m_irq_en, busy, m_flag, m_in};
  endfunction

  task automatic start_model(input int p, input int n);
    p_nc = m_nc; p_P = m_P; p_N = m_N; p_act = m_act;
    m_act = 1;
    m_P = (p == 0) ? 1 : p;
    m_N = n;
    m_nc = tickn;
  endtask

  task automatic tick();
    @(negedge clk);
    tickn++;
    chk("ack_pulse", {31'd0, prev_ack & ack}, 32'd0);
    if (!ack) chk("dat_idle", dato, 32'd0);
`ifndef MGMT_GPIO_IRQ_EN
    chk("irq_tied", {31'd0, girq}, 32'd0);
`endif
    if (chk_pad) chk("pad_out", {31'd0, gout}, {31'd0, model_pad(tickn)});
    prev_ack = ack;
  endtask

  task automatic xfer(input logic we, input logic [3:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat,
                      output logic [31:0] rdat, output int r0);
    int   n;
    logic got;
    rdat = '0; got = 1'b0; n = 0;
    r0 = tickn;
    cyc = 1'b1; stb = 1'b1; wbwe = we;
    wbadr = adr; wbsel = sel; wbdat = dat;
    while (!got && n < 8) begin
      tick();
      n++;
      if (ack) begin
        got = 1'b1;
        rdat = dato;
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    tick();
    cyc = 1'b0; stb = 1'b0; wbwe = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat);
    logic [31:0] d;
    int r;
    xfer(1'b1, adr, sel, dat, d, r);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] d,
                    output int r0);
    xfer(1'b0, adr, 4'hF, 32'd0, d, r0);
  endtask

  task automatic run_blink(input int p, input int n, input logic ov);
    logic [31:0] d;
    int r0;
    chk_pad = 1'b0;
    wr(4'h0, 4'hF, {26'd0, 6'h22 | {5'd0, ov}});
    tick(); tick();
    m_ov = ov; m_act = 0; p_act = 0;
    chk_pad = 1'b1;
    wr(4'h4, 4'hF, 32'(p));
    wr(4'h8, 4'hF, 32'(n));
    start_model(p, n);
    while (tickn < m_nc + 2 * m_P * n + 2) begin
      rd(4'h8, d, r0);
      chk("count_rd", d, exp_count(r0));
      rd(4'hC, d, r0);
      chk("busy_rd", d, exp_stat(exp_busy(r0)));
    end
    repeat (3) tick();
    rd(4'hC, d, r0);
    chk("busy_end", d, exp_stat(1'b0));
    rd(4'h8, d, r0);
    chk("count_end", d, 32'd0);
    chk_pad = 1'b0;
  endtask

  task automatic chk_pads(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, gout, goeb, gieb, gm0, gm1}, {27'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int r0;
    logic [5:0] v;
    int p, n;

    // reset state
    repeat (3) tick();
    chk_pads("pads_in_rst", 5'b01000);
    chk("ack_in_rst", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    tick();
    chk_pads("pads_rst", 5'b01000);
    chk("irq_rst", {31'd0, girq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d, r0);
      chk("reg_rst", d, 32'd0);
    end

    // CTRL static drive, then a lane-masked write
    wr(4'h0, 4'hF, 32'h03);
    chk("oeb_ctrl", {31'd0, goeb}, 32'd0);
    tick();
    chk_pads("pads_ctrl3", 5'b10100);
    wr(4'h0, 4'h0, 32'h3C);
    tick();
    chk_pads("pads_sel0", 5'b10100);
    rd(4'h0, d, r0);
    chk("ctrl_sel0", d, 32'h03);

    // random CTRL patterns
    for (int i = 0; i < 4; i++) begin
      v = 6'($urandom);
      wr(4'h0, 4'h1, {26'd0, v});
      tick();
      chk_pads("pads_rnd", {v[0], ~v[1], ~v[2], v[3], v[4]});
      rd(4'h0, d, r0);
      chk("ctrl_rnd", d, {26'd0, v});
    end

    // PERIOD byte lanes; bits above PW are dropped
    wr(4'h4, 4'hF, 32'hFFABCDEF);
    rd(4'h4, d, r0);
    chk("per_full", d, 32'h00ABCDEF);
    wr(4'h4, 4'h2, 32'h00123456);
    rd(4'h4, d, r0);
    chk("per_lane1", d, 32'h00AB34EF);

    // directed blink then random blinks
    run_blink(5, 3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      p = int'($urandom_range(1, 4));
      n = int'($urandom_range(1, 3));
      run_blink(p, n, 1'($urandom));
    end

    // continuous toggle, then restart with a finite count
    wr(4'h0, 4'hF, 32'h22);
    tick(); tick();
    m_ov = 1'b0; m_act = 0; p_act = 0;
    chk_pad = 1'b1;
    wr(4'h4, 4'hF, 32'd0);
    rd(4'h4, d, r0);
    chk("per_zero", d, 32'd0);
    wr(4'h8, 4'hF, 32'd0);
    start_model(0, 0);
    repeat (7) tick();
    rd(4'h8, d, r0);
    chk("count_cont", d, 32'd0);
    rd(4'hC, d, r0);
    chk("busy_cont", d, exp_stat(1'b1));
    wr(4'h8, 4'hF, 32'd2);
    start_model(0, 2);
    rd(4'h8, d, r0);
    chk("count_restart", d, exp_count(r0));
    repeat (6) tick();
    rd(4'hC, d, r0);
    chk("busy_restart", d, exp_stat(1'b0));
    chk_pad = 1'b0;

    // asynchronous input toggles
    for (int i = 0; i < 3; i++) begin
      tick();
      #($urandom_range(1, 4));
      gin = ~gin;
      m_in = gin;
      m_flag = 1'b1;
      repeat (SS + 2) tick();
      rd(4'hC, d, r0);
      chk("stat_edge", d, exp_stat(1'b0));
    end
    wr(4'hC, 4'h1, 32'h2);
    m_flag = 1'b0;
    rd(4'hC, d, r0);
    chk("stat_w1c", d, exp_stat(1'b0));

    // W1C landing on the same cycle as a new edge
    tick();
    #2;
    gin = ~gin;
    m_in = gin;
    repeat (SS - 1) tick();
    wr(4'hC, 4'h1, 32'h2);
    m_flag = 1'b1;
    repeat (SS + 1) tick();
    rd(4'hC, d, r0);
    chk("stat_collide", d, exp_stat(1'b0));
    wr(4'hC, 4'h1, 32'h2);
    m_flag = 1'b0;
    rd(4'hC, d, r0);
    chk("stat_clr2", d, exp_stat(1'b0));

    // irq enable
    wr(4'hC, 4'h1, 32'h8);
`ifdef MGMT_GPIO_IRQ_EN
    m_irq_en = 1'b1;
`endif
    rd(4'hC, d, r0);
    chk("stat_irqen", d, exp_stat(1'b0));
`ifdef MGMT_GPIO_IRQ_EN
    tick();
    #2;
    gin = ~gin;
    m_in = gin;
    repeat (SS + 1) tick();
    chk("irq_lag", {31'd0, girq}, 32'd0);
    tick();
    chk("irq_set", {31'd0, girq}, 32'd1);
    m_flag = 1'b1;
    wr(4'hC, 4'h1, 32'hA);
    m_flag = 1'b0;
    chk("irq_hold", {31'd0, girq}, 32'd1);
    tick();
    chk("irq_clr", {31'd0, girq}, 32'd0);
`endif

    // reset during a blink and an open bus request
    gin = 1'b0;
    repeat (SS + 2) tick();
    wr(4'h4, 4'hF, 32'd2);
    wr(4'h8, 4'hF, 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; wbwe = 1'b0; wbadr = 4'h8;
    tick();
    chk("ack_abort", {31'd0, ack}, 32'd0);
    chk_pads("pads_midrst", 5'b01000);
    tick();
    chk("ack_abort2", {31'd0, ack}, 32'd0);
    chk_pads("pads_midrst2", 5'b01000);
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    m_irq_en = 1'b0; m_flag = 1'b0; m_in = 1'b0;
    m_act = 0;
    tick();
    chk_pads("pads_after", 5'b01000);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d, r0);
      chk("reg_after", d, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
